// File: rtl/pmod_input_unit.sv
// Four-button PMOD front end: synchronize, debounce, turn rising edges into
// press events, queue them in a pending mask and hand them out one at a time
// through a valid/ready command register with a sticky drop flag.
module pmod_input_unit #(
    parameter int unsigned DEBOUNCE_TICKS = 1000000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [3:0] i_btn,
    input  logic       i_cmd_ready,
    input  logic       i_ovf_clear,
    output logic       o_cmd_valid,
    output logic [1:0] o_cmd,
    output logic [3:0] o_level,
    output logic       o_overflow
);

    localparam int unsigned NBTN  = 4;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]                 rst_sync_q;
    logic                       rst_n;
    logic [NBTN-1:0]            sync1_q;
    logic [NBTN-1:0]            sync2_q;
    logic [NBTN-1:0][CNT_W-1:0] cnt_q;
    logic [NBTN-1:0][CNT_W-1:0] cnt_d;
    logic [NBTN-1:0]            deb_q;
    logic [NBTN-1:0]            deb_d;
    logic [NBTN-1:0]            press_c;
    logic [NBTN-1:0]            pending_q;
    logic [NBTN-1:0]            pending_d;
    logic [NBTN-1:0]            clear_mask_c;
    logic [IDX_W-1:0]           idx_c;
    logic                       free_c;
    logic                       load_c;
    logic                       ovf_evt_c;
    logic                       valid_q;
    logic                       valid_d;
    logic [IDX_W-1:0]           cmd_q;
    logic [IDX_W-1:0]           cmd_d;
    logic                       ovf_q;
    logic                       ovf_d;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_TICKS consecutive mismatches.
    always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        press_c = '0;
        for (int k = 0; k < int'(NBTN); k++) begin
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == CNT_TERM) begin
                    deb_d[k]   = sync2_q[k];
                    press_c[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    // Lowest pending index wins the output register whenever it is free.
    always_comb begin
        idx_c = '0;
        for (int k = int'(NBTN) - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                idx_c = IDX_W'(k);
            end
        end
    end

    // Pending mask, command register and overflow next-state.
    always_comb begin
        free_c       = !valid_q || i_cmd_ready;
        load_c       = free_c && (pending_q != '0);
        clear_mask_c = '0;
        valid_d      = valid_q;
        cmd_d        = cmd_q;
        if (load_c) begin
            clear_mask_c[idx_c] = 1'b1;
            cmd_d               = idx_c;
        end
        if (free_c) begin
            valid_d = load_c;
        end
        // A press on a still-pending button is dropped; a same-edge clear lets it in.
        ovf_evt_c = |(press_c & pending_q & ~clear_mask_c);
        pending_d = (pending_q & ~clear_mask_c) | press_c;
        ovf_d     = ovf_evt_c | (ovf_q & ~i_ovf_clear);
    end

    // State registers for debounce, queueing and output stage.
    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            deb_q     <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            cmd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_cmd_valid = valid_q;
    assign o_cmd       = cmd_q;
    assign o_level     = deb_q;
    assign o_overflow  = ovf_q;

endmodule
